// File: rtl/latch_loader_pkg.sv
// Shared types and sizing helpers for the latch word loader.
package latch_loader_pkg;

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/latch_word_loader_pulse_timer.sv
// Down-counter that sets how long the latch enable stays open.
module pulse_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] LOAD_VAL = TW'(HOLD_CYCLES - 1);

    logic [TW-1:0] cnt;

    // Loaded with HOLD_CYCLES-1 so the terminal count is reached on the last open cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/latch_word_loader.sv
// Deserialises a valid/ready bit stream and writes each word into a D-latch bank with a timed enable.
//   state | meaning
//   SHIFT | collecting serial bits into the shadow register
//   SETUP | D settled, enable still closed
//   OPEN  | enable held open for HOLD_CYCLES
//   CLOSE | enable closed, D held, done raised
module latch_word_loader
    import latch_loader_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ser_d,
    input  logic                      ser_valid,
    output logic                      ser_ready,
    input  logic                      clr,
    output logic [WIDTH-1:0]          D,
    output logic                      En,
    output logic                      busy,
    output logic                      done,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

    localparam int CNT_W = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_nxt;
    logic             accept;
    logic             last_bit;
    logic             tmr_expire;

    // Flops are already held in reset while rst_n is low, so it only gates the port.
    assign ser_ready = (state == SHIFT) & rst_n & ~clr;
    assign accept    = ser_valid & (state == SHIFT) & ~clr;
    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state != SHIFT);

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shadow_nxt = {shadow[WIDTH-2:0], ser_d};
        end else begin : g_lsb
            assign shadow_nxt = {ser_d, shadow[WIDTH-1:1]};
        end
    endgenerate

    pulse_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == SETUP),
        .run   (state == OPEN),
        .expire(tmr_expire)
    );

    // En and done are registered from the state, so each lags its state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SHIFT;
            shadow  <= '0;
            D       <= '0;
            bit_cnt <= '0;
            En      <= 1'b0;
            done    <= 1'b0;
        end else if (clr) begin
            state   <= SHIFT;
            shadow  <= '0;
            bit_cnt <= '0;
            En      <= 1'b0;
            done    <= 1'b0;
        end else begin
            En   <= (state == OPEN);
            done <= (state == CLOSE);
            case (state)
                SHIFT: begin
                    if (accept) begin
                        if (last_bit) begin
                            D       <= shadow_nxt;
                            shadow  <= '0;
                            bit_cnt <= '0;
                            state   <= SETUP;
                        end else begin
                            shadow  <= shadow_nxt;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                SETUP: state <= OPEN;
                OPEN: begin
                    if (tmr_expire) begin
                        state <= CLOSE;
                    end
                end
                CLOSE:   state <= SHIFT;
                default: state <= SHIFT;
            endcase
        end
    end

endmodule
